// File: rtl/vedic_pkg.sv
// Shared definitions for the iterative 8x8 Vedic multiplier: FSM states,
// number of partial-product steps and result width.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Four 4x4 partial products make up one 8x8 product.
  localparam int STEP_COUNT = 4;
  localparam int STEP_W     = $clog2(STEP_COUNT);
  localparam int PROD_W     = 16;

endpackage

// File: rtl/vedic_4x4.sv
// Combinational 4x4 unsigned multiplier built Vedic-style from four 2x2
// vertical/crosswise products.
module vedic_4x4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] prod
);

  logic [3:0] p_ll, p_hl, p_lh, p_hh;

  assign p_ll = {2'b00, x[1:0]} * {2'b00, y[1:0]};
  assign p_hl = {2'b00, x[3:2]} * {2'b00, y[1:0]};
  assign p_lh = {2'b00, x[1:0]} * {2'b00, y[3:2]};
  assign p_hh = {2'b00, x[3:2]} * {2'b00, y[3:2]};

  // Crosswise terms sit two bit positions up, the high-high term four.
  assign prod = {4'h0, p_ll}
              + {2'b00, p_hl, 2'b00}
              + {2'b00, p_lh, 2'b00}
              + {p_hh, 4'h0};

endmodule

// File: rtl/vedic_mul8_iter.sv
// Iterative 8x8 unsigned multiplier: one shared vedic_4x4 core accumulates
// the four nibble partial products over four cycles, then presents the
// product with a valid/ready handshake.
module vedic_mul8_iter
  import vedic_pkg::*;
#(
  parameter bit CLR_ON_ACCEPT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p,
  output logic              busy
);

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [PROD_W-1:0]   acc;
  logic [7:0]          a_q;
  logic [7:0]          b_q;

  logic [3:0]          op_x;
  logic [3:0]          op_y;
  logic [7:0]          pp;
  logic [PROD_W-1:0]   pp_shift;
  logic [PROD_W-1:0]   sum;

  // Step 0: aL*bL, 1: aH*bL, 2: aL*bH, 3: aH*bH.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pp_shift = {8'h00, pp};
    op_x     = step[0] ? a_q[7:4] : a_q[3:0];
    op_y     = step[1] ? b_q[7:4] : b_q[3:0];
    case (step)
      2'd1, 2'd2: pp_shift = {8'h00, pp} << 4;
      2'd3:       pp_shift = {8'h00, pp} << 8;
      default:    pp_shift = {8'h00, pp};
    endcase
  end

  vedic_4x4 u_core (
    .x    (op_x),
    .y    (op_y),
    .prod (pp)
  );

  assign sum = acc + pp_shift;

  // Control FSM plus datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      state <= IDLE;
      step  <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            step  <= '0;
            state <= MUL;
            if (CLR_ON_ACCEPT) p <= '0;
          end
        end
        MUL: begin
          acc  <= sum;
          step <= step + STEP_W'(1);
          if (step == STEP_W'(STEP_COUNT - 1)) begin
            p     <= sum;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags are pure decodes of the registered state.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == MUL);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_vedic_mul8_iter.sv
// Self-checking bench for vedic_mul8_iter: directed scenarios plus random
// operations, compared against plain a*b. Two instances share the inputs,
// one with CLR_ON_ACCEPT=0 and one with CLR_ON_ACCEPT=1.
module tb_vedic_mul8_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a, b;
  logic        out_ready;
  logic        in_ready, out_valid, busy;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] p0, p1;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] last_prod;   // model of the held result (CLR_ON_ACCEPT=0)

  always #5 clk = ~clk;

  vedic_mul8_iter #(.CLR_ON_ACCEPT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p0), .busy(busy)
  );

  vedic_mul8_iter #(.CLR_ON_ACCEPT(1'b1)) dut_clr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .p(p1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  // One full operation starting from IDLE at a negedge. stall = cycles with
  // out_ready low in DONE; junk = keep in_valid high with other operands.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input int stall, input bit junk);
    logic [15:0] exp;
    int  k;
    bit  seen;
    exp = model(x, y);
    check("in_ready_idle", in_ready, 1);
    a = x; b = y; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clk);
    if (junk) begin a = 8'h11; b = 8'h11; end else in_valid = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 10; k++) begin
      if (out_valid) begin seen = 1'b1; break; end
      check("busy_mul", busy, 1);
      check("in_ready_mul", in_ready, 0);
      check("p_hold", p0, last_prod);
      check("p_clr", p1, 0);
      @(negedge clk);
    end
    if (!seen) begin
      check("out_valid_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    check("latency", k, 4);
    check("p", p0, exp);
    check("p_clrinst", p1, exp);
    check("busy_done", busy, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_p", p0, exp);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_p", p0, exp);
    last_prod = exp;
  endtask

  initial begin
    logic [15:0] exp_q[$];
    int          acc_cyc[$];
    logic [15:0] e;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    last_prod = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_p", p0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);
    check("rel_busy", busy, 0);

    // Directed scenarios.
    run_op(8'h12, 8'h34, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 0, 1'b0);
    run_op(8'h00, 8'hA5, 0, 1'b0);
    run_op(8'h0F, 8'hF0, 5, 1'b0);
    run_op(8'h9C, 8'h07, 2, 1'b1);

    // Reset during step 2.
    a = 8'hAB; b = 8'hCD; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_p", p0, 0);
    check("midrst_p_clr", p1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_prod = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("after_rst_no_valid", out_valid, 0);
    end
    run_op(8'h02, 8'h03, 0, 1'b0);

    // Random operations.
    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("b2b_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("b2b_p", p0, e);
          check("b2b_p_clrinst", p1, e);
          last_prod = e;
        end
      end
      if (busy) begin
        check("b2b_p_hold", p0, last_prod);
        check("b2b_p_clr", p1, 0);
      end
      in_valid = (cyc < 45);
      if (in_ready && in_valid) begin
        a = 8'($urandom); b = 8'($urandom);
        exp_q.push_back(model(a, b));
        acc_cyc.push_back(cyc);
      end
      @(negedge clk);
    end
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_ops", acc_cyc.size(), 8);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
